// File: rtl/cfeb_rdout_rcvr.sv
// rtl/cfeb_rdout_rcvr.sv - CFEB readout receiver: input capture, FWFT FIFO, frame checker
// Build option: define CFEB_RCVR_CRC_CHECK_EN to enable the check-word XOR compare.
module cfeb_rdout_rcvr #(
  parameter int FIFO_AW = 6,
  parameter int TMO_CYC = 255
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        LPUSH_B,
  input  logic        ENDWORD,
  input  logic [15:0] DIN,
  input  logic        DREADY,
  output logic [15:0] DOUT,
  output logic        DVALID,
  output logic        DLAST,
  output logic        FRM_DONE,
  output logic        CRCERR,
  output logic        OVFERR,
  output logic        TOERR,
  output logic [11:0] WCNT,
  output logic        BUSY
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam int TW = $clog2(TMO_CYC + 1);
  localparam logic [TW-1:0] TMO_MAX = TW'(TMO_CYC);

  typedef enum logic [1:0] {IDLE, RECV, CHECK} state_t;

  // RST asserts everything at once; release is retimed through two flops
  logic [1:0] rst_sync;
  logic       rst_i;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) rst_sync <= 2'b11;
    else     rst_sync <= {rst_sync[0], 1'b0};
  end
  assign rst_i = rst_sync[1];

  logic        push_r, end_r;
  logic [15:0] din_r;

  always_ff @(posedge CLK or posedge rst_i) begin
    if (rst_i) begin
      push_r <= 1'b0;
      end_r  <= 1'b0;
      din_r  <= '0;
    end else begin
      push_r <= ~LPUSH_B;
      end_r  <= ENDWORD;
      din_r  <= DIN;
    end
  end

  logic [16:0]      mem [DEPTH];
  logic [FIFO_AW:0] wptr, rptr, fill;
  logic [16:0]      head;
  logic             empty, full, rd, wr;

  assign fill  = wptr - rptr;
  assign empty = (fill == '0);
  assign full  = fill[FIFO_AW];
  assign rd    = ~empty & DREADY;
  // a full FIFO still takes the word when a slot frees on the same edge
  assign wr    = push_r & (~full | rd);
  assign head  = mem[rptr[FIFO_AW-1:0]];

  always_ff @(posedge CLK) begin
    if (wr) mem[wptr[FIFO_AW-1:0]] <= {end_r, din_r};
  end

  always_ff @(posedge CLK or posedge rst_i) begin
    if (rst_i) begin
      wptr   <= '0;
      rptr   <= '0;
      OVFERR <= 1'b0;
    end else begin
      if (wr) wptr <= wptr + 1'b1;
      if (rd) rptr <= rptr + 1'b1;
      if (push_r & ~wr) OVFERR <= 1'b1;
    end
  end

  assign DVALID = ~empty;
  assign DOUT   = empty ? 16'h0000 : head[15:0];
  assign DLAST  = ~empty & head[16];

  state_t        state, state_nx;
  logic [11:0]   cnt;
  logic [TW-1:0] tmo;
  logic          start, tmo_hit;

  always_ff @(posedge CLK or posedge rst_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    FRM_DONE = 1'b0;
    start    = 1'b0;
    tmo_hit  = 1'b0;
    case (state)
      IDLE, CHECK: begin
        FRM_DONE = (state == CHECK);
        state_nx = IDLE;
        if (push_r) begin
          start    = 1'b1;
          state_nx = end_r ? CHECK : RECV;
        end
      end
      RECV: begin
        if (push_r) begin
          if (end_r) state_nx = CHECK;
        end else if (tmo == TMO_MAX) begin
          tmo_hit  = 1'b1;
          FRM_DONE = 1'b1;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // counting happens on every registered push, including ones the FIFO drops
  always_ff @(posedge CLK or posedge rst_i) begin
    if (rst_i) begin
      cnt   <= '0;
      tmo   <= '0;
      WCNT  <= '0;
      TOERR <= 1'b0;
    end else begin
      if (push_r) begin
        tmo <= '0;
        if (start)               cnt <= 12'd1;
        else if (cnt != 12'hFFF) cnt <= cnt + 12'd1;
      end else if (state == RECV) begin
        tmo <= tmo + TW'(1);
      end
      if (FRM_DONE) WCNT  <= cnt;
      if (tmo_hit)  TOERR <= 1'b1;
    end
  end

`ifdef CFEB_RCVR_CRC_CHECK_EN
  logic [15:0] csum, chk_word;
  logic        crcerr;

  always_ff @(posedge CLK or posedge rst_i) begin
    if (rst_i) begin
      csum     <= '0;
      chk_word <= '0;
      crcerr   <= 1'b0;
    end else begin
      if (state == CHECK && chk_word != csum) crcerr <= 1'b1;
      if (push_r) begin
        if (end_r)       chk_word <= din_r;
        if (start)       csum <= end_r ? 16'h0000 : din_r;
        else if (!end_r) csum <= csum ^ din_r;
      end
    end
  end
  assign CRCERR = crcerr;
`else
  assign CRCERR = 1'b0;
`endif

  assign BUSY = (state != IDLE);

endmodule

// File: doc/cfeb_rdout_rcvr.md
CFEB_RDOUT_RCVR -- requirements
Module: cfeb_rdout_rcvr

Interface
REQ-001 The block SHALL have parameter FIFO_AW, default 6, giving the FIFO address width (depth 2**FIFO_AW words).
REQ-002 The block SHALL have parameter TMO_CYC, default 255, giving the RECV-state clocks without a push before the frame is abandoned.
REQ-003 Ports SHALL be as follows, clock and reset first:
  CLK        in   1   single clock, 40 MHz readout domain (one clock; reset is asynchronous and active-high)
  RST        in   1   asynchronous active-high reset
  LPUSH_B    in   1   active-low word strobe from CFEB
  ENDWORD    in   1   marks the pushed word as the frame check word
  DIN        in   16  CFEB readout word
  DREADY     in   1   downstream accepts DOUT
  DOUT       out  16  FIFO head word
  DVALID     out  1   DOUT valid
  DLAST      out  1   DOUT is the last word of its frame
  FRM_DONE   out  1   one-clock pulse at frame close
  CRCERR     out  1   sticky: check word mismatch
  OVFERR     out  1   sticky: word dropped on a full FIFO
  TOERR      out  1   sticky: frame timed out
  WCNT       out  12  word count of the last closed frame
  BUSY       out  1   state is not IDLE

Function
REQ-004 LPUSH_B, ENDWORD and DIN SHALL be registered once on the CLK rising edge before any use (push = registered LPUSH_B low).
REQ-005 A registered push SHALL write {ENDWORD, DIN} into a 17-bit FIFO on the next edge, so the write completes two edges after LPUSH_B is sampled low.
REQ-006 The FIFO SHALL be first-word-fall-through: DVALID SHALL be high whenever it is non-empty, and DOUT/DLAST SHALL show the head entry.
REQ-007 A read SHALL occur on an edge where DVALID and DREADY are both high.
REQ-008 A write SHALL be accepted when the FIFO is not full, or when it is full and a read occurs on the same edge.
REQ-009 Any other write SHALL be dropped and SHALL set OVFERR.
REQ-010 The FSM SHALL have the states IDLE, RECV and CHECK.
REQ-011 IDLE to RECV SHALL occur on a push without ENDWORD; that push clears the checksum, word count and timeout counter.
REQ-012 IDLE to CHECK SHALL occur on a push with ENDWORD; this is a single-word frame checked against a checksum of 0.
REQ-013 RECV to CHECK SHALL occur on a push with ENDWORD.
REQ-014 RECV to IDLE SHALL occur when the timeout counter reaches TMO_CYC; this sets TOERR and pulses FRM_DONE.
REQ-015 CHECK to IDLE SHALL occur unconditionally after one clock; FRM_DONE SHALL pulse in CHECK.
REQ-016 The checksum SHALL be the bitwise XOR of all non-ENDWORD words of the frame.
REQ-017 Words dropped on overflow SHALL still be included in the checksum and the count.
REQ-018 The word count SHALL include the check word, SHALL saturate at 4095, and SHALL load into WCNT at frame close (CHECK or timeout).
REQ-019 The timeout counter SHALL clear on every push in RECV and increment otherwise.
REQ-020 A push arriving while in CHECK SHALL start a new frame, exactly as if the state were IDLE.
REQ-021 CRCERR, OVFERR and TOERR SHALL be cleared only by RST.
REQ-022 BUSY SHALL be high in RECV and CHECK.

Reset
REQ-023 On RST high, the FSM SHALL go to IDLE and the FIFO pointers SHALL be emptied.
REQ-024 On RST high, DVALID, DLAST, FRM_DONE, CRCERR, OVFERR, TOERR and BUSY SHALL be 0, WCNT SHALL be 0 and DOUT SHALL be 16'h0000.
REQ-025 The input registers, checksum and counters SHALL clear on RST.
REQ-026 RST mid-frame SHALL discard the partial frame, with no FRM_DONE pulse.
REQ-027 Release of RST SHALL be synchronised internally: logic SHALL leave reset on the second CLK edge after RST falls.

Configuration
REQ-028 Macro CFEB_RCVR_CRC_CHECK_EN SHALL control the checksum feature.
REQ-029 With CFEB_RCVR_CRC_CHECK_EN defined, in CHECK the ENDWORD data SHALL be compared with the checksum, and a mismatch SHALL set CRCERR.
REQ-030 Without CFEB_RCVR_CRC_CHECK_EN, the checksum logic SHALL be absent and CRCERR SHALL be tied 0; all other behaviour SHALL be unchanged.

Verification
REQ-031 Frame test: pushes 16'h0001, 16'h0002, 16'h0004, then ENDWORD 16'h0007, DREADY=1 -> DOUT sequence 1,2,4,7 with DLAST only on 7; FRM_DONE one pulse; WCNT=4; CRCERR=0.
REQ-032 Bad check word (macro defined): same frame with check word 16'h0006 -> CRCERR=1 after CHECK and stays 1 through the next good frame; with the macro undefined, CRCERR=0.
REQ-033 Overflow: FIFO_AW=2, DREADY=0, push 6 words then ENDWORD -> first 4 words retained, OVFERR=1, WCNT=7.
REQ-034 Full boundary: with the FIFO full and DREADY=1 on the same edge as a write -> the write is accepted, no OVFERR, and the FIFO stays full.
REQ-035 Timeout: TMO_CYC=10, push 2 words and then stop -> TOERR=1 and FRM_DONE pulse 10 clocks after the last push, WCNT=2, BUSY=0.
REQ-036 Reset mid-frame: RST asserted after 3 pushes -> DVALID=0 immediately; no FRM_DONE; the next frame behaves as in REQ-031.
